// File: rtl/ppm16_mod_if.sv
// Packet-side bus of the 16-PPM modulator: start/length request, symbol feed
// with ready/valid handshake, and the chip stream plus status back out.
interface ppm16_mod_if;
   logic        tx_start;
   logic [15:0] data_len;
   logic [3:0]  din;
   logic        din_valid;
   logic        din_ready;
   logic        dout;
   logic        busy;
   logic        tx_done;
   logic        tx_underrun;

   modport master (
      output tx_start, data_len, din, din_valid,
      input  din_ready, dout, busy, tx_done, tx_underrun
   );

   modport slave (
      input  tx_start, data_len, din, din_valid,
      output din_ready, dout, busy, tx_done, tx_underrun
   );
endinterface

// File: rtl/ppm16_mod.sv
// 16-PPM packet modulator: preamble (0/F alternating), 4-nibble length header,
// then buffered data symbols; one chip high per symbol, CHIP_BITS cycles each.
module ppm16_mod #(
   parameter int CHIP_BITS    = 3,
   parameter int PREAMBLE_LEN = 8
) (
   input  logic       clk,
   input  logic       resetn,
   ppm16_mod_if.slave bus
);

   localparam int BW = (CHIP_BITS > 1) ? $clog2(CHIP_BITS) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(CHIP_BITS - 1);
   localparam logic [15:0]   PRE_LAST = 16'(PREAMBLE_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_HDR, S_DATA} state_t;

   state_t        r_state, w_nxt_state;
   logic [BW-1:0] r_bit, w_nxt_bit;
   logic [3:0]    r_chip, w_nxt_chip;
   logic [15:0]   r_sym, w_nxt_sym;
   logic [3:0]    r_val, w_nxt_val;
   logic [15:0]   r_len, r_fetched;
   logic [3:0]    r_buf;
   logic          r_full, r_dout, r_done, r_und;
   logic          w_sym_end, w_bnd, w_consume, w_underrun, w_done, w_nxt_dout;
   logic          w_busy, w_ready, w_xfer;

   function automatic logic [3:0] hdr_nib(input logic [15:0] len, input logic [1:0] idx);
      unique case (idx)
         2'd0: return len[15:12];
         2'd1: return len[11:8];
         2'd2: return len[7:4];
         2'd3: return len[3:0];
      endcase
   endfunction

   assign w_sym_end = (r_bit == LAST_BIT) && (r_chip == 4'd15);
   assign w_xfer    = bus.din_valid && w_ready;

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_nxt_state;
   end

   // Counters here describe the position dout will show next cycle, so the
   // registered dout lines up with the state it belongs to.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_bit   = r_bit + BW'(1);
      w_nxt_chip  = r_chip;
      w_nxt_sym   = r_sym;
      w_nxt_val   = r_val;
      w_bnd       = 1'b0;
      w_consume   = 1'b0;
      w_underrun  = 1'b0;
      w_done      = 1'b0;
      if (r_bit == LAST_BIT) begin
         w_nxt_bit  = '0;
         w_nxt_chip = r_chip + 4'd1;
      end
      unique case (r_state)
         S_IDLE: begin
            w_nxt_bit  = '0;
            w_nxt_chip = '0;
            w_nxt_sym  = '0;
            w_nxt_val  = 4'h0;
            if (bus.tx_start) w_nxt_state = S_PRE;
         end
         S_PRE: begin
            if (w_sym_end) begin
               if (r_sym == PRE_LAST) begin
                  w_nxt_state = S_HDR;
                  w_nxt_sym   = '0;
                  w_nxt_val   = r_len[15:12];
               end else begin
                  w_nxt_sym = r_sym + 16'd1;
                  w_nxt_val = r_sym[0] ? 4'h0 : 4'hF;
               end
            end
         end
         S_HDR: begin
            if (w_sym_end) begin
               if (r_sym == 16'd3) begin
                  if (r_len != 16'd0) begin
                     w_nxt_state = S_DATA;
                     w_nxt_sym   = '0;
                     w_bnd       = 1'b1;
                  end else begin
                     w_nxt_state = S_IDLE;
                     w_done      = 1'b1;
                  end
               end else begin
                  w_nxt_sym = r_sym + 16'd1;
                  w_nxt_val = hdr_nib(r_len, r_sym[1:0] + 2'd1);
               end
            end
         end
         S_DATA: begin
            if (r_und) begin
               w_nxt_state = S_IDLE;
            end else if (w_sym_end) begin
               if (r_sym == r_len - 16'd1) begin
                  w_nxt_state = S_IDLE;
                  w_done      = 1'b1;
               end else begin
                  w_nxt_sym = r_sym + 16'd1;
                  w_bnd     = 1'b1;
               end
            end
         end
      endcase
      if (w_bnd) begin
         if (r_full) begin
            w_consume = 1'b1;
            w_nxt_val = r_buf;
         end else begin
            w_underrun = 1'b1;
         end
      end
      w_nxt_dout = (w_nxt_state != S_IDLE) && !w_underrun && !r_und &&
                   (w_nxt_chip == w_nxt_val);
   end

   // While idle only the accepting cycle may prefetch; the buffer is cleared there.
   always_comb begin
      w_busy  = (r_state != S_IDLE);
      w_ready = w_busy ? (!r_full && (r_fetched < r_len))
                       : (bus.tx_start && (bus.data_len != 16'd0));
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_bit     <= '0;
         r_chip    <= '0;
         r_sym     <= '0;
         r_val     <= '0;
         r_len     <= '0;
         r_fetched <= '0;
         r_buf     <= '0;
         r_full    <= 1'b0;
         r_dout    <= 1'b0;
         r_done    <= 1'b0;
         r_und     <= 1'b0;
      end else begin
         r_bit  <= w_nxt_bit;
         r_chip <= w_nxt_chip;
         r_sym  <= w_nxt_sym;
         r_val  <= w_nxt_val;
         r_dout <= w_nxt_dout;
         r_done <= w_done;
         r_und  <= w_underrun;
         if (r_state == S_IDLE) begin
            r_full    <= w_xfer;
            r_fetched <= {15'd0, w_xfer};
            if (w_xfer)       r_buf <= bus.din;
            if (bus.tx_start) r_len <= bus.data_len;
         end else if (w_xfer) begin
            r_full    <= 1'b1;
            r_buf     <= bus.din;
            r_fetched <= r_fetched + 16'd1;
         end else if (w_consume) begin
            r_full <= 1'b0;
         end
      end
   end

   assign bus.dout        = r_dout;
   assign bus.busy        = w_busy;
   assign bus.din_ready   = w_ready;
   assign bus.tx_done     = r_done;
   assign bus.tx_underrun = r_und;

endmodule
